// File: rtl/sva_req_initiator.sv
// sva_req_initiator: antecedent/consequent handshake initiator with bounded response window.
// Define SVA_REQ_INITIATOR_ASSERT_EN to compile in the embedded protocol assertions.
module sva_req_initiator #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             consequent,
  output logic             antecedent,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             spurious,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             ante_q, ante_d, done_q, done_d, to_q, to_d, sp_q, sp_d;
  logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    sp_d    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = REQ; else sp_d = consequent;
      REQ: begin
        state_d = WAIT;
        wcnt_d  = WW'(1);
      end
      WAIT: begin
        if (consequent) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == TMO) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else wcnt_d = wcnt_q + WW'(1);
      end
      default: state_d = IDLE;
    endcase
    ante_d = state_d == REQ;
    ok_d   = (done_d && ok_q != '1) ? ok_q + CNT_W'(1) : ok_q;
    err_d  = ((to_d || sp_d) && err_q != '1) ? err_q + CNT_W'(1) : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ante_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      sp_q    <= 1'b0;
      ok_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ante_q  <= ante_d;
      done_q  <= done_d;
      to_q    <= to_d;
      sp_q    <= sp_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end
  assign antecedent = ante_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign timeout    = to_q;
  assign spurious   = sp_q;
  assign ok_count   = ok_q;
  assign err_count  = err_q;
`ifdef SVA_REQ_INITIATOR_ASSERT_EN
  a_ante_pulse: assert property (@(posedge clk) disable iff (reset) antecedent |=> !antecedent)
    else $error("a_ante_pulse ok=%0d err=%0d", $sampled(ok_count), $sampled(err_count));
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0({done, timeout, spurious}))
    else $error("a_onehot ok=%0d err=%0d", $sampled(ok_count), $sampled(err_count));
  a_done_idle: assert property (@(posedge clk) disable iff (reset) done |-> !busy)
    else $error("a_done_idle ok=%0d err=%0d", $sampled(ok_count), $sampled(err_count));
  a_ante_busy: assert property (@(posedge clk) disable iff (reset) antecedent |=> busy)
    else $error("a_ante_busy ok=%0d err=%0d", $sampled(ok_count), $sampled(err_count));
  a_start_ign: assert property (@(posedge clk) disable iff (reset) busy && !antecedent |-> !start || busy)
    else $error("a_start_ign ok=%0d err=%0d", $sampled(ok_count), $sampled(err_count));
`endif
endmodule

// File: tb/tb_sva_req_initiator.sv
// tb_sva_req_initiator: randomized and directed checks of sva_req_initiator against a request-age model.
module tb_sva_req_initiator;
  localparam int TMO  = 4;
  localparam int CW   = 3;
  localparam int MAXC = 7;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cons_man = 1'b0, resp_q = 1'b0;
  logic consequent, antecedent, busy, done, timeout, spurious;
  logic [CW-1:0] ok_count, err_count;
  int mode = 0;
  int n_cmp = 0, n_fail = 0;
  int age = 0, m_ok = 0, m_err = 0;
  logic m_done = 1'b0, m_to = 1'b0, m_sp = 1'b0;
  logic [10:0] exp_v;

  sva_req_initiator #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .consequent(consequent),
    .antecedent(antecedent), .busy(busy), .done(done), .timeout(timeout),
    .spurious(spurious), .ok_count(ok_count), .err_count(err_count));

  always #5 clk = ~clk;
  // mode 1: registered responder, mode 2: responder answering in the request cycle
  always @(posedge clk) resp_q <= reset ? 1'b0 : antecedent;
  assign consequent = mode == 1 ? resp_q : mode == 2 ? antecedent : cons_man;

  function automatic logic [10:0] obs();
    return {antecedent, busy, done, timeout, spurious, ok_count, err_count};
  endfunction

  // age = cycles since start was accepted; 0 means no request outstanding
  task automatic tick(input logic s, input logic c, input logic r);
    start = s;
    cons_man = c;
    reset = r;
    @(negedge clk);
    m_done = 1'b0;
    m_to = 1'b0;
    m_sp = 1'b0;
    if (reset) begin
      age = 0;
      m_ok = 0;
      m_err = 0;
    end else if (age == 0) begin
      if (start) age = 1;
      else if (consequent) begin
        m_sp = 1'b1;
        m_err = m_err < MAXC ? m_err + 1 : m_err;
      end
    end else if (age == 1) age = 2;
    else if (consequent) begin
      m_done = 1'b1;
      m_ok = m_ok < MAXC ? m_ok + 1 : m_ok;
      age = 0;
    end else if (age == TMO + 1) begin
      m_to = 1'b1;
      m_err = m_err < MAXC ? m_err + 1 : m_err;
      age = 0;
    end else age++;
    exp_v = {age == 1, age != 0, m_done, m_to, m_sp, CW'(m_ok), CW'(m_err)};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 0;
    tick(0, 0, 1);
    tick(0, 0, 1);
    n_cmp++;
    if (obs() !== 11'b0) begin n_fail++; $display("FAIL reset_vals got %h exp 000", obs()); end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      n_cmp++;
      if (obs() !== 11'b0) begin n_fail++; $display("FAIL reset_idle cyc%0d got %h exp 000", i, obs()); end
    end
  endtask

  task automatic test_single();
    int ante_at = -1, done_at = -1, busy_n = 0;
    tick(0, 0, 1);
    mode = 1;
    for (int j = 1; j <= 6; j++) begin
      tick(j == 1, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL single_model cyc%0d got %h exp %h", j, obs(), exp_v); end
      if (antecedent && ante_at < 0) ante_at = j;
      if (done && done_at < 0) done_at = j;
      if (busy) busy_n++;
    end
    n_cmp++;
    if (ante_at !== 1 || done_at !== 3 || busy_n !== 2 || ok_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_latency got ante=%0d done=%0d busy=%0d ok=%0d exp 1 3 2 1", ante_at, done_at, busy_n, ok_count);
    end
  endtask

  task automatic test_timeout();
    int to_at = -1;
    tick(0, 0, 1);
    mode = 0;
    for (int j = 1; j <= 10; j++) begin
      tick(j == 1, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL timeout_model cyc%0d got %h exp %h", j, obs(), exp_v); end
      if (timeout && to_at < 0) to_at = j;
    end
    n_cmp++;
    if (to_at !== TMO + 2 || err_count !== 3'd1 || ok_count !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_latency got at=%0d err=%0d ok=%0d exp %0d 1 0", to_at, err_count, ok_count, TMO + 2);
    end
  endtask

  task automatic test_spurious();
    tick(0, 0, 1);
    mode = 0;
    tick(0, 1, 0);
    n_cmp++;
    if (spurious !== 1'b1 || err_count !== 3'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_pulse got sp=%b err=%0d busy=%b exp 1 1 0", spurious, err_count, busy);
    end
    tick(0, 0, 0);
    n_cmp++;
    if (obs() !== exp_v || spurious !== 1'b0) begin n_fail++; $display("FAIL spurious_clear got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_back_to_back();
    int last = -1, gap_bad = 0, n_req = 0;
    tick(0, 0, 1);
    mode = 1;
    for (int j = 1; j <= 20; j++) begin
      tick(1, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_model cyc%0d got %h exp %h", j, obs(), exp_v); end
      if (antecedent) begin
        if (last >= 0 && j - last != 3) gap_bad++;
        last = j;
        n_req++;
      end
    end
    n_cmp++;
    if (ok_count !== 3'd6 || gap_bad != 0 || n_req != 7) begin
      n_fail++;
      $display("FAIL b2b_spacing got ok=%0d badgaps=%0d reqs=%0d exp 6 0 7", ok_count, gap_bad, n_req);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    tick(0, 0, 1);
    mode = 1;
    tick(1, 0, 0);
    tick(0, 0, 0);
    n_cmp++;
    if (busy !== 1'b1 || consequent !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got busy=%b cons=%b exp 1 1", busy, consequent); end
    tick(0, 0, 1);
    n_cmp++;
    if (obs() !== 11'b0) begin n_fail++; $display("FAIL midrst_vals got %h exp 000", obs()); end
    for (int j = 0; j < 5; j++) begin
      tick(0, 0, 0);
      if (obs() !== 11'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_quiet got %0d nonzero cycles exp 0", seen); end
  endtask

  task automatic test_saturation();
    tick(0, 0, 1);
    mode = 1;
    for (int j = 1; j <= 45; j++) begin
      tick(1, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL sat_ok_model cyc%0d got %h exp %h", j, obs(), exp_v); end
    end
    n_cmp++;
    if (ok_count !== 3'd7) begin n_fail++; $display("FAIL sat_ok got %0d exp 7", ok_count); end
    tick(0, 0, 0);
    tick(0, 0, 0);
    mode = 0;
    for (int j = 1; j <= 12; j++) tick(0, 1, 0);
    n_cmp++;
    if (err_count !== 3'd7 || ok_count !== 3'd7 || spurious !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_err got err=%0d ok=%0d sp=%b exp 7 7 1", err_count, ok_count, spurious);
    end
  endtask

  task automatic test_early_responder();
    int to_at = -1, dn = 0;
    tick(0, 0, 1);
    mode = 2;
    for (int j = 1; j <= 9; j++) begin
      tick(j == 1, 0, 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL early_model cyc%0d got %h exp %h", j, obs(), exp_v); end
      if (timeout && to_at < 0) to_at = j;
      if (done) dn++;
    end
    n_cmp++;
    if (to_at !== TMO + 2 || dn != 0 || ok_count !== 3'd0) begin
      n_fail++;
      $display("FAIL early_resp got to_at=%0d dones=%0d ok=%0d exp %0d 0 0", to_at, dn, ok_count, TMO + 2);
    end
  endtask

  task automatic test_random();
    tick(0, 0, 1);
    for (int j = 0; j < 3000; j++) begin
      if (j % 50 == 0) mode = $urandom_range(0, 2);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
      n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL random cyc%0d mode%0d got %h exp %h", j, mode, obs(), exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_early_responder();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
